// File: rtl/display_arbiter.sv
// Display arbiter: live game digits by default, event messages shown for a fixed hold then a live gap.
// Optional message blink compiled in with DISPLAY_ARBITER_BLINK_EN.
module display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 200_000_000,
    parameter int unsigned MIN_LIVE    = 50_000_000
`ifdef DISPLAY_ARBITER_BLINK_EN
    ,
    parameter int unsigned BLINK_HALF  = 25_000_000
`endif
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [47:0] live_data_i,
    input  logic [47:0] msg_data_i,
    input  logic        msg_valid_i,
    output logic        msg_ready_o,
    input  logic        msg_abort_i,
    output logic        owner_o,
    output logic [5:0]  d1_o,
    output logic [5:0]  d2_o,
    output logic [5:0]  d3_o,
    output logic [5:0]  d4_o,
    output logic [5:0]  d5_o,
    output logic [5:0]  d6_o,
    output logic [5:0]  d7_o,
    output logic [5:0]  d8_o
);

    localparam int unsigned HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam int unsigned GW = (MIN_LIVE < 1) ? 1 : $clog2(MIN_LIVE + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(MIN_LIVE - 1);

    typedef enum logic [1:0] {
        S_LIVE = 2'd0,
        S_MSG  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [47:0]   buf_q, buf_d;
    logic [47:0]   disp_q, disp_d;
    logic          owner_q, owner_d;

`ifdef DISPLAY_ARBITER_BLINK_EN
    localparam int unsigned BW = (BLINK_HALF < 1) ? 1 : $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        buf_d   = buf_q;
        disp_d  = live_data_i;
        owner_d = 1'b0;
`ifdef DISPLAY_ARBITER_BLINK_EN
        blink_d = blink_q;
        phase_d = phase_q;
`endif
        case (state_q)
            S_LIVE: begin
                if (msg_valid_i) begin
                    buf_d   = msg_data_i;
                    hold_d  = HOLD_LOAD;
                    state_d = S_MSG;
`ifdef DISPLAY_ARBITER_BLINK_EN
                    blink_d = '0;
                    phase_d = 1'b0;
`endif
                end
            end
            S_MSG: begin
                owner_d = 1'b1;
`ifdef DISPLAY_ARBITER_BLINK_EN
                disp_d = phase_q ? 48'h0 : buf_q;
                if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    blink_d = blink_q + BW'(1);
                end
`else
                disp_d = buf_q;
`endif
                // Abort and hold expiry share one exit path into the live gap
                if (msg_abort_i || (hold_q == '0)) begin
                    hold_d = '0;
                    if (MIN_LIVE == 0) begin
                        state_d = S_LIVE;
                    end else begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_LIVE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = S_LIVE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_LIVE;
            hold_q  <= '0;
            gap_q   <= '0;
            buf_q   <= '0;
            disp_q  <= '0;
            owner_q <= 1'b0;
`ifdef DISPLAY_ARBITER_BLINK_EN
            blink_q <= '0;
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            buf_q   <= buf_d;
            disp_q  <= disp_d;
            owner_q <= owner_d;
`ifdef DISPLAY_ARBITER_BLINK_EN
            blink_q <= blink_d;
            phase_q <= phase_d;
`endif
        end
    end

    assign msg_ready_o = (state_q == S_LIVE);
    assign owner_o     = owner_q;
    assign d1_o        = disp_q[5:0];
    assign d2_o        = disp_q[11:6];
    assign d3_o        = disp_q[17:12];
    assign d4_o        = disp_q[23:18];
    assign d5_o        = disp_q[29:24];
    assign d6_o        = disp_q[35:30];
    assign d7_o        = disp_q[41:36];
    assign d8_o        = disp_q[47:42];

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: timeline-window reference model checked every cycle plus directed literal checks.
module tb_display_arbiter;

    localparam int H  = 4;
    localparam int M  = 2;
    localparam int BH = 1;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [47:0] live_data_i = '0;
    logic [47:0] msg_data_i = '0;
    logic        msg_valid_i = 1'b0;
    logic        msg_abort_i = 1'b0;
    logic        msg_ready_o, owner_o;
    logic [5:0]  d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o;

    int tests = 0;
    int fails = 0;

    display_arbiter #(
        .HOLD_CYCLES(H),
        .MIN_LIVE(M)
`ifdef DISPLAY_ARBITER_BLINK_EN
        ,
        .BLINK_HALF(BH)
`endif
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .live_data_i(live_data_i), .msg_data_i(msg_data_i),
        .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
        .msg_abort_i(msg_abort_i), .owner_o(owner_o),
        .d1_o(d1_o), .d2_o(d2_o), .d3_o(d3_o), .d4_o(d4_o),
        .d5_o(d5_o), .d6_o(d6_o), .d7_o(d7_o), .d8_o(d8_o)
    );

    always #5 clock_i = ~clock_i;

    wire [47:0] d_bus = {d8_o, d7_o, d6_o, d5_o, d4_o, d3_o, d2_o, d1_o};

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the message occupies edge-intervals [acc, end_msg), the gap [end_msg, end_gap).
    int          kc, acc, end_msg, end_gap;
    logic [47:0] mbuf;

    localparam int P_LIVE = 0, P_MSG = 1, P_GAP = 2;

    function automatic int phase_at(input int t);
        if (t >= acc && t < end_msg) return P_MSG;
        if (t >= end_msg && t < end_gap) return P_GAP;
        return P_LIVE;
    endfunction

    task automatic model_reset();
        acc = kc; end_msg = kc; end_gap = kc; mbuf = '0;
    endtask

    always @(posedge clock_i) begin
        int          sp;
        logic [47:0] ed;
        logic        eo;
        if (!reset_i) begin
            sp = phase_at(kc);
            kc++;
            if (sp == P_MSG) begin
                eo = 1'b1;
                ed = mbuf;
`ifdef DISPLAY_ARBITER_BLINK_EN
                if ((((kc - 1 - acc) / BH) % 2) == 1) ed = '0;
`endif
            end else begin
                eo = 1'b0;
                ed = live_data_i;
            end
            if (sp == P_LIVE && msg_valid_i) begin
                acc = kc; end_msg = kc + H; end_gap = kc + H + M; mbuf = msg_data_i;
            end else if (sp == P_MSG && msg_abort_i) begin
                end_msg = kc; end_gap = kc + M;
            end
            #1;
            chk("model_digits", d_bus, ed);
            chk("model_owner", {47'h0, owner_o}, {47'h0, eo});
            chk("model_ready", {47'h0, msg_ready_o}, {47'h0, phase_at(kc) == P_LIVE});
        end
    end

    function automatic logic [47:0] rnd48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[47:0];
    endfunction

    task automatic step();
        @(negedge clock_i);
    endtask

    task automatic post();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            msg_valid_i = 1'b0;
            msg_abort_i = 1'b0;
            live_data_i = rnd48();
        end
    endtask

    initial begin
        int          acc_cnt;
        logic [5:0]  exp_d1;
        logic [47:0] t48;
        kc = 0;
        model_reset();
        #1;
        chk("reset_digits", d_bus, 48'h0);
        chk("reset_owner", {47'h0, owner_o}, 48'h0);
        chk("reset_ready", {47'h0, msg_ready_o}, 48'h1);
        step();
        reset_i = 1'b0;
        idle(3);

        // Single pulse, message changes and live changes after acceptance
        step();
        msg_valid_i = 1'b1;
        t48 = rnd48();
        msg_data_i = {t48[47:6], 6'h2A};
        post();
        chk("pulse_ready_T", {47'h0, msg_ready_o}, 48'h0);
        step();
        msg_valid_i = 1'b0;
        msg_data_i = rnd48();
        t48 = rnd48();
        live_data_i = {t48[47:6], 6'h33};
        for (int i = 1; i <= 4; i++) begin
            post();
            exp_d1 = 6'h2A;
`ifdef DISPLAY_ARBITER_BLINK_EN
            if ((i % 2) == 0) exp_d1 = 6'h00;
`endif
            chk("pulse_d1", {42'h0, d1_o}, {42'h0, exp_d1});
            chk("pulse_owner", {47'h0, owner_o}, 48'h1);
            chk("pulse_ready_low", {47'h0, msg_ready_o}, 48'h0);
        end
        post();
        chk("pulse_live_d1", {42'h0, d1_o}, {42'h0, 6'h33});
        chk("pulse_owner_T5", {47'h0, owner_o}, 48'h0);
        chk("pulse_ready_T5", {47'h0, msg_ready_o}, 48'h0);
        post();
        chk("pulse_ready_T6", {47'h0, msg_ready_o}, 48'h1);
        idle(2);

        // Valid held high: one acceptance per H+M cycles
        acc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            msg_valid_i = 1'b1;
            msg_data_i = rnd48();
            #1;
            if (msg_ready_o) acc_cnt++;
        end
        chk("held_accept_count", 48'(acc_cnt), 48'd2);
        idle(8);

        // Abort on the second MSG cycle, then abort in LIVE is ignored
        step();
        msg_valid_i = 1'b1;
        msg_data_i = rnd48();
        post();
        step();
        msg_valid_i = 1'b0;
        post();
        chk("abort_owner_T1", {47'h0, owner_o}, 48'h1);
        step();
        msg_abort_i = 1'b1;
        post();
        chk("abort_owner_T2", {47'h0, owner_o}, 48'h1);
        step();
        msg_abort_i = 1'b0;
        post();
        chk("abort_owner_T3", {47'h0, owner_o}, 48'h0);
        chk("abort_ready_T3", {47'h0, msg_ready_o}, 48'h0);
        post();
        chk("abort_ready_T4", {47'h0, msg_ready_o}, 48'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            msg_abort_i = 1'b1;
            post();
            chk("abort_live_ready", {47'h0, msg_ready_o}, 48'h1);
            chk("abort_live_owner", {47'h0, owner_o}, 48'h0);
        end
        idle(2);

        // Reset mid-message
        step();
        msg_valid_i = 1'b1;
        msg_data_i = rnd48();
        post();
        step();
        msg_valid_i = 1'b0;
        post();
        #3;
        reset_i = 1'b1;
        #1;
        chk("midrst_digits", d_bus, 48'h0);
        chk("midrst_owner", {47'h0, owner_o}, 48'h0);
        chk("midrst_ready", {47'h0, msg_ready_o}, 48'h1);
        model_reset();
        step();
        t48 = rnd48();
        live_data_i = {t48[47:6], 6'h21};
        reset_i = 1'b0;
        post();
        chk("midrst_live_d1", {42'h0, d1_o}, {42'h0, 6'h21});

        // Randomized traffic, with held-valid bursts and one reset
        for (int i = 0; i < 3000; i++) begin
            step();
            live_data_i = rnd48();
            msg_data_i = rnd48();
            msg_valid_i = ((i / 200) % 3 == 2) ? 1'b1 : ($urandom_range(99) < 30);
            msg_abort_i = ($urandom_range(99) < 8);
            if (i == 1500) begin
                #2;
                reset_i = 1'b1;
                #1;
                chk("rnd_rst_digits", d_bus, 48'h0);
                model_reset();
                step();
                reset_i = 1'b0;
            end
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the 8-digit seven-segment display between two requesters: the live game-state digits (default owner) and a high-priority event-message source (e.g. "WIN", attempt count, error banners). Sits between the game core and `dspl_drv_NexysA7`, driving its `d1`..`d8` inputs. A message is accepted by valid/ready handshake, shown for a fixed hold time, then the display reverts to live data for a guaranteed minimum interval before the next message is accepted.

## Interface
- HOLD_CYCLES, 200_000_000, cycles a message stays on the display (≥1)
- MIN_LIVE, 50_000_000, cycles of live display enforced after each message (≥0)
- BLINK_HALF, 25_000_000, half-period of message blink in cycles (≥1; used only with blink compiled in)

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- live_data  in  48  live digits, packed; [5:0]=d1 … [47:42]=d8
- msg_data  in  48  message digits, same packing
- msg_valid  in  1  message request
- msg_ready  out  1  message accepted when msg_valid & msg_ready
- msg_abort  in  1  end current message immediately
- owner  out  1  0 = live, 1 = message (registered, matches d1..d8)
- d1..d8  out  6 each  digit codes to display driver; bit 5 = digit enable, 6'h00 = blank

## Operation
- States: LIVE, MSG, GAP. Reset → LIVE, hold/gap/blink counters 0, message buffer 0.
- msg_ready = (state==LIVE), combinational from state; high immediately after reset.
- LIVE: on msg_valid & msg_ready, msg_data latched into buffer, hold counter loaded HOLD_CYCLES-1, blink counter cleared, → MSG.
- MSG: hold counter decrements each cycle; at 0 → GAP (MIN_LIVE>0, gap counter loaded MIN_LIVE-1) or LIVE (MIN_LIVE=0). msg_abort high → same exit immediately, regardless of counter.
- GAP: live data shown; gap counter decrements; at 0 → LIVE. msg_valid ignored (ready low).
- msg_abort ignored in LIVE and GAP. msg_valid with msg_abort in LIVE: message accepted.
- Selection: MSG → buffer (or blank phase, see Configuration); LIVE/GAP → live_data, passed through every cycle (live changes tracked while displayed).
- Message buffer contents fixed while in MSG; msg_data changes after acceptance have no effect.
- Reset mid-message: message discarded, outputs blank, LIVE.

## Timing
- Reset values: d1..d8 = 6'h00, owner = 0, msg_ready = 1.
- d1..d8 and owner registered: reflect the state/selection of the previous cycle (1-cycle latency).
- Handshake at edge T → state MSG from T; d/owner show message from edge T+1.
- Message visible exactly HOLD_CYCLES cycles (absent abort); live visible in GAP exactly MIN_LIVE cycles; msg_ready returns HOLD_CYCLES+MIN_LIVE cycles after acceptance edge.
- Abort sampled at edge A → state exits at A; owner=0 from A+1.
- Live data latency in LIVE/GAP: 1 cycle.
- Counter widths: $clog2(param+1), minimum 1 bit; no wrap — counters stop at 0.

## Configuration
- DISPLAY_ARBITER_BLINK_EN defined: during MSG, blink counter counts 0..BLINK_HALF-1 and toggles a phase bit at wrap; phase 0 (first BLINK_HALF cycles after acceptance) shows message, phase 1 shows all digits 6'h00. owner stays 1 in both phases. Phase resets to 0 on each acceptance.
- Undefined: message shown steadily for whole hold; blink counter and BLINK_HALF unused/absent.

## Test plan
(HOLD_CYCLES=4, MIN_LIVE=2, BLINK_HALF=1)
- Reset asserted mid-MSG → d1..d8=0, owner=0, msg_ready=1 immediately; after release live_data=48'h…(d1=6'h21) appears on d1 after 1 edge.
- msg_valid pulse, msg_data d1=6'h2A at edge T → d1=6'h2A, owner=1 for edges T+1..T+4; live from T+5; msg_ready low T..T+5, high from T+6.
- msg_valid held high continuously → accepted once per 6 cycles; second message not shown before 2 live cycles.
- msg_abort at 2nd MSG cycle → owner=0 next edge, GAP of 2 cycles, then msg_ready=1; msg_abort in LIVE → no effect.
- msg_data changed after acceptance, live_data changed during MSG → display keeps latched message; new live value shown at first GAP cycle.
- With DISPLAY_ARBITER_BLINK_EN: message accepted at T → d1 alternates msg/6'h00/msg/6'h00 over T+1..T+4, owner=1 throughout.
